// File: rtl/sobel_pkg.sv
// sobel_pkg: shared state type and parameter defaults
// for the Sobel frame scheduler.
package sobel_pkg;

  localparam int PX_W_DEF    = 8;
  localparam int DIM_W_DEF   = 8;
  localparam int ADDR_W_DEF  = 16;
  localparam int GAP_DEF     = 2;
  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W       = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_GAP,
    S_FILL,
    S_STEP,
    S_WAIT_RES,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/sobel_addr_gen.sv
// sobel_addr_gen: strip/row position and multiplier-free
// read and write address generation.
module sobel_addr_gen
  import sobel_pkg::*;
#(
  parameter int DIM_W  = DIM_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              nreset_i,
  input  logic [DIM_W-1:0]  w_i,
  input  logic [DIM_W-1:0]  h_i,
  input  logic              clr_i,
  input  logic              rd_adv_i,
  input  logic              row_step_i,
  input  logic              strip_step_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              last_row_o,
  output logic              last_col_o
);

  localparam logic [DIM_W:0] THREE = (DIM_W+1)'(3);

  logic [DIM_W-1:0]  x_q, x_d;
  logic [DIM_W-1:0]  y_q, y_d;
  logic [1:0]        c_q, c_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] out_base_q, out_base_d;
  logic [ADDR_W-1:0] w_a;

  assign w_a = ADDR_W'(w_i);

  // row_base is the start of the next pixel row to fetch
  assign rd_addr_o = row_base_q
                   + ADDR_W'(x_q)
                   + ADDR_W'(c_q);
  assign wr_addr_o = out_base_q + ADDR_W'(x_q);

  assign last_row_o = ({1'b0, y_q} + THREE)
                      >= {1'b0, h_i};
  assign last_col_o = ({1'b0, x_q} + THREE)
                      >= {1'b0, w_i};

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    c_d        = c_q;
    row_base_d = row_base_q;
    out_base_d = out_base_q;
    if (clr_i || strip_step_i) begin
      x_d        = clr_i ? '0 : x_q + 1'b1;
      y_d        = '0;
      c_d        = '0;
      row_base_d = '0;
      out_base_d = '0;
    end else begin
      if (rd_adv_i) begin
        if (c_q == 2'd2) begin
          c_d        = '0;
          row_base_d = row_base_q + w_a;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      if (row_step_i) begin
        y_d        = y_q + 1'b1;
        out_base_d = out_base_q + w_a
                   - ADDR_W'(2);
      end
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      x_q        <= '0;
      y_q        <= '0;
      c_q        <= '0;
      row_base_q <= '0;
      out_base_q <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      c_q        <= c_d;
      row_base_q <= row_base_d;
      out_base_q <= out_base_d;
    end
  end

endmodule

// File: rtl/sobel_frame_scheduler.sv
// sobel_frame_scheduler: walks a frame in vertical strips,
// feeds 3x3 windows to the Sobel controller, stores results.
module sobel_frame_scheduler
  import sobel_pkg::*;
#(
  parameter int PX_W       = PX_W_DEF,
  parameter int DIM_W      = DIM_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int GAP_CYCLES = GAP_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              nreset_i,
  input  logic              start_frame_i,
  input  logic [DIM_W-1:0]  img_width_i,
  input  logic [DIM_W-1:0]  img_height_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  input  logic [PX_W-1:0]   mem_rd_data_i,
  output logic              sobel_start_o,
  output logic [PX_W-1:0]   sobel_px_o,
  output logic              sobel_px_rdy_o,
  input  logic [PX_W-1:0]   sobel_res_i,
  input  logic              sobel_res_rdy_i,
  output logic              out_wr_en_o,
  output logic [ADDR_W-1:0] out_wr_addr_o,
  output logic [PX_W-1:0]   out_wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  sched_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIM_W-1:0]  w_q, w_d;
  logic [DIM_W-1:0]  h_q, h_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              px_rdy_q;
  logic              start_q, start_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PX_W-1:0]   wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              issue;
  logic              ag_clr;
  logic              ag_row;
  logic              ag_strip;
  logic [ADDR_W-1:0] ag_rd_addr;
  logic [ADDR_W-1:0] ag_wr_addr;
  logic              ag_last_row;
  logic              ag_last_col;
  logic              bad_dim;

  assign bad_dim = (w_q < DIM_W'(3))
                || (h_q < DIM_W'(3));

  sobel_addr_gen #(
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk_i        (clk_i),
    .nreset_i     (nreset_i),
    .w_i          (w_q),
    .h_i          (h_q),
    .clr_i        (ag_clr),
    .rd_adv_i     (issue),
    .row_step_i   (ag_row),
    .strip_step_i (ag_strip),
    .rd_addr_o    (ag_rd_addr),
    .wr_addr_o    (ag_wr_addr),
    .last_row_o   (ag_last_row),
    .last_col_o   (ag_last_col)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_d       = w_q;
    h_d       = h_q;
    start_d   = start_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    issue     = 1'b0;
    ag_clr    = 1'b0;
    ag_row    = 1'b0;
    ag_strip  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_frame_i) begin
          state_d = S_CHECK;
          w_d     = img_width_i;
          h_d     = img_height_i;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          ag_clr  = 1'b1;
        end
      end
      S_CHECK: begin
        cnt_d = '0;
        if (bad_dim) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          state_d = S_FILL;
          start_d = 1'b1;
          cnt_d   = '0;
          issue   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FILL: begin
        if (cnt_q == CNT_W'(8)) begin
          state_d = S_WAIT_RES;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          issue = 1'b1;
        end
      end
      S_STEP: begin
        if (cnt_q == CNT_W'(2)) begin
          state_d = S_WAIT_RES;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          issue = 1'b1;
        end
      end
      S_WAIT_RES: begin
        // first cycle here carries the last pixel strobe
        if (sobel_res_rdy_i) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ag_wr_addr;
          wr_data_d = sobel_res_i;
          cnt_d     = '0;
          if (!ag_last_row) begin
            ag_row  = 1'b1;
            issue   = 1'b1;
            state_d = S_STEP;
          end else if (!ag_last_col) begin
            ag_strip = 1'b1;
            start_d  = 1'b0;
            state_d  = S_GAP;
          end else begin
            start_d = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          start_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rd_en_d   = issue;
    rd_addr_d = issue ? ag_rd_addr : rd_addr_q;
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      w_q       <= '0;
      h_q       <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      px_rdy_q  <= 1'b0;
      start_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_q       <= w_d;
      h_q       <= h_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      px_rdy_q  <= rd_en_q;
      start_q   <= start_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // RAM data arrives one cycle after the strobe
  assign sobel_px_o     = px_rdy_q ? mem_rd_data_i : '0;
  assign sobel_px_rdy_o = px_rdy_q;
  assign mem_rd_en_o    = rd_en_q;
  assign mem_rd_addr_o  = rd_addr_q;
  assign sobel_start_o  = start_q;
  assign out_wr_en_o    = wr_en_q;
  assign out_wr_addr_o  = wr_addr_q;
  assign out_wr_data_o  = wr_data_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = err_q;

endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// tb_sobel_frame_scheduler: frame-level reference model,
// Sobel responder and per-cycle output checks.
module tb_sobel_frame_scheduler;

  localparam int TMO = 16;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_frame;
  logic [7:0]  img_w, img_h;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic        s_start;
  logic [7:0]  s_px;
  logic        s_px_rdy;
  logic [7:0]  s_res;
  logic        s_res_rdy;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy, done, err;

  always #5 clk = ~clk;

  sobel_frame_scheduler dut (
    .clk_i           (clk),
    .nreset_i        (rst_n),
    .start_frame_i   (start_frame),
    .img_width_i     (img_w),
    .img_height_i    (img_h),
    .mem_rd_en_o     (rd_en),
    .mem_rd_addr_o   (rd_addr),
    .mem_rd_data_i   (rd_data),
    .sobel_start_o   (s_start),
    .sobel_px_o      (s_px),
    .sobel_px_rdy_o  (s_px_rdy),
    .sobel_res_i     (s_res),
    .sobel_res_rdy_i (s_res_rdy),
    .out_wr_en_o     (wr_en),
    .out_wr_addr_o   (wr_addr),
    .out_wr_data_o   (wr_data),
    .busy_o          (busy),
    .done_o          (done),
    .error_o         (err)
  );

  logic [7:0] ram [0:4095];
  always @(posedge clk)
    if (rd_en) rd_data <= ram[rd_addr[11:0]];

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  // reference: window weights 1..9 in row-major order
  function automatic int win_f(int x, int y, int w);
    int s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += int'(ram[(y + r) * w + x + c])
             * (3 * r + c + 1);
    return s & 255;
  endfunction

  int exp_rd[$];
  int exp_wa[$];
  int exp_wd[$];
  int got_rd[$];
  int got_wa[$];
  int rd_idx, wr_idx, done_cnt;
  int cyc = 0;
  int last_px_cyc, done_cyc;
  bit mute = 0;

  task automatic build(input int w, input int h,
                       input bit mt);
    exp_rd.delete();
    exp_wa.delete();
    exp_wd.delete();
    if (w < 3 || h < 3) return;
    for (int x = 0; x <= w - 3; x++) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          exp_rd.push_back(r * w + x + c);
      if (mt) return;
      for (int y = 1; y <= h - 3; y++)
        for (int c = 0; c < 3; c++)
          exp_rd.push_back((y + 2) * w + x + c);
      for (int y = 0; y <= h - 3; y++) begin
        exp_wa.push_back(y * (w - 2) + x);
        exp_wd.push_back(win_f(x, y, w));
      end
    end
  endtask

  // Sobel controller stand-in: answers 3 cycles after each window
  int px_cnt;
  int cd;
  logic [7:0] win [9];
  always @(negedge clk) begin
    if (!rst_n) begin
      px_cnt = 0;
      cd = 0;
      s_res_rdy = 1'b0;
      s_res = '0;
    end else begin
      s_res_rdy = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) s_res_rdy = 1'b1;
      end
      if (!s_start) px_cnt = 0;
      if (s_px_rdy) begin
        for (int i = 0; i < 8; i++) win[i] = win[i + 1];
        win[8] = s_px;
        px_cnt++;
        if (!mute && px_cnt >= 9
            && (px_cnt - 9) % 3 == 0) begin
          int s;
          s = 0;
          for (int i = 0; i < 9; i++)
            s += int'(win[i]) * (i + 1);
          s_res = 8'(s);
          cd = 3;
        end
      end
    end
  end

  logic [15:0] prev_addr;
  bit prev_rd, prev_start;
  int low_run;
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (rd_en) begin
        got_rd.push_back(int'(rd_addr));
        if (rd_idx < exp_rd.size())
          chk("rd_addr", rd_addr, exp_rd[rd_idx]);
        else
          chk("rd_extra", rd_idx, exp_rd.size());
        rd_idx++;
      end
      chk("px_rdy", s_px_rdy, prev_rd);
      if (s_px_rdy) begin
        chk("px_data", s_px, ram[prev_addr[11:0]]);
        last_px_cyc = cyc;
      end
      if (s_start && !prev_start) begin
        chk("gap_low", low_run >= GAP ? GAP : low_run,
            GAP);
        chk("start_with_fill", rd_en, 1);
      end
      low_run = s_start ? 0 : low_run + 1;
      if (wr_en) begin
        got_wa.push_back(int'(wr_addr));
        if (wr_idx < exp_wa.size()) begin
          chk("wr_addr", wr_addr, exp_wa[wr_idx]);
          chk("wr_data", wr_data, exp_wd[wr_idx]);
        end else begin
          chk("wr_extra", wr_idx, exp_wa.size());
        end
        wr_idx++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_rd = rd_en;
      prev_addr = rd_addr;
      prev_start = s_start;
    end else begin
      prev_rd = 0;
      prev_start = 0;
      low_run = 0;
    end
  end

  task automatic run_frame(input int w, input int h,
                           input bit mt,
                           input int repulse_at,
                           input bit exp_err,
                           output int lat);
    mute = mt;
    build(w, h, mt);
    rd_idx = 0;
    wr_idx = 0;
    done_cnt = 0;
    got_rd.delete();
    got_wa.delete();
    @(negedge clk);
    start_frame = 1'b1;
    img_w = 8'(w);
    img_h = 8'(h);
    @(negedge clk);
    start_frame = 1'b0;
    img_w = 8'($urandom);
    img_h = 8'($urandom);
    chk("busy_rise", busy, 1);
    lat = -1;
    for (int i = 1; i < 3000; i++) begin
      @(negedge clk);
      start_frame = (i == repulse_at);
      if (done) begin
        lat = i + 1;
        break;
      end
    end
    start_frame = 1'b0;
    if (lat < 0) chk("done_seen", 0, 1);
    repeat (3) @(negedge clk);
    chk("busy_fall", busy, 0);
    chk("done_once", done_cnt, 1);
    chk("error", err, exp_err);
    chk("n_reads", rd_idx, exp_rd.size());
    chk("n_writes", wr_idx, exp_wa.size());
  endtask

  int lat, diff, w, h;
  bit found;
  int lit_rd[12] = '{0, 1, 2, 4, 5, 6,
                     8, 9, 10, 12, 13, 14};
  int lit_wa[4] = '{0, 2, 1, 3};

  initial begin
    start_frame = 1'b0;
    img_w = '0;
    img_h = '0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'(i);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs",
        {rd_en, rd_addr, s_start, s_px, s_px_rdy,
         wr_en, wr_addr, wr_data, busy, done, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(4, 4, 0, 0, 0, lat);
    for (int i = 0; i < 12; i++)
      chk("t1_rd", i < got_rd.size() ? got_rd[i] : -1,
          lit_rd[i]);
    for (int i = 0; i < 4; i++)
      chk("t1_wa", i < got_wa.size() ? got_wa[i] : -1,
          lit_wa[i]);

    run_frame(3, 3, 0, 0, 0, lat);
    chk("t2_wa0", got_wa.size() > 0 ? got_wa[0] : -1, 0);

    run_frame(2, 5, 0, 0, 1, lat);
    chk("t3_done_lat", lat, 2);

    run_frame(4, 4, 1, 0, 1, lat);
    diff = done_cyc - last_px_cyc;
    total++;
    if (diff < TMO || diff > TMO + 2) begin
      bad++;
      $display("FAIL timeout_window: got %0d want %0d..%0d",
               diff, TMO, TMO + 2);
    end

    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    run_frame(6, 5, 0, 20, 0, lat);

    mute = 0;
    build(8, 8, 0);
    rd_idx = 0;
    wr_idx = 0;
    done_cnt = 0;
    @(negedge clk);
    start_frame = 1'b1;
    img_w = 8'd8;
    img_h = 8'd8;
    @(negedge clk);
    start_frame = 1'b0;
    found = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rd_en && rd_addr == 16'd24) begin
        found = 1;
        break;
      end
    end
    chk("step_reached", found, 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_outs",
        {rd_en, rd_addr, s_start, s_px, s_px_rdy,
         wr_en, wr_addr, wr_data, busy, done, err}, 0);
    repeat (3) @(negedge clk);
    chk("no_done_on_reset", done_cnt, 0);
    rst_n = 1'b1;
    run_frame(8, 8, 0, 0, 0, lat);
    chk("t6_writes", wr_idx, 36);

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
      w = int'($urandom_range(3, 9));
      h = int'($urandom_range(3, 9));
      run_frame(w, h, 0, 0, 0, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
